// File: rtl/feather_pkg.sv
// Shared Feather core definitions: multiply-unit FSM encoding and register-file constants.
package feather_pkg;

  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add MUL/MLA unit, N+1 cycles accept-to-write; start_i is ignored while busy_o is high.
// MUL_EARLY_EXIT_EN ends iteration once the remaining multiplier bits are all zero.
module mul_unit
  import feather_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [N-1:0]          op_a_i,
  input  logic [N-1:0]          op_b_i,
  input  logic [N-1:0]          acc_i,
  input  logic                  accumulate_i,
  input  logic                  set_flags_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N-1:0]          result_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  write_enable_o,
  output logic                  flag_n_o,
  output logic                  flag_z_o,
  output logic                  flags_valid_o
);

  localparam int CNT_W = $clog2(N);

  mul_state_t            state_q, state_d;
  logic [N-1:0]          mcand_q, mplier_q, prod_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  sf_q;

  logic                  accept, zero_b_start, calc_last, calc_done;
  logic [N-1:0]          prod_init, prod_nxt, mplier_nxt;

  assign accept     = start_i && (state_q != CALC);
  assign prod_init  = accumulate_i ? acc_i : '0;
  assign prod_nxt   = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign mplier_nxt = mplier_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign zero_b_start = accept && (op_b_i == '0);
  assign calc_last    = (mplier_nxt == '0) || (cnt_q == CNT_W'(N - 1));
`else
  assign zero_b_start = 1'b0;
  assign calc_last    = (cnt_q == CNT_W'(N - 1));
`endif

  assign calc_done = (state_q == CALC) && calc_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_b_start ? DONE : CALC;
      CALC:    if (calc_last) state_d = DONE;
      DONE:    state_d = accept ? (zero_b_start ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      sf_q     <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
      flag_n_o <= 1'b0;
      flag_z_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q  <= op_a_i;
        mplier_q <= op_b_i;
        prod_q   <= prod_init;
        cnt_q    <= '0;
        rd_q     <= rd_i;
        sf_q     <= set_flags_i;
      end else if (state_q == CALC) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_nxt;
        prod_q   <= prod_nxt;
        cnt_q    <= cnt_q + 1'b1;
      end
      // Result, address and flags are captured on the edge that enters DONE.
      if (calc_done) begin
        result_o <= prod_nxt;
        rd_o     <= rd_q;
        if (sf_q) begin
          flag_n_o <= prod_nxt[N-1];
          flag_z_o <= (prod_nxt == '0);
        end
      end else if (zero_b_start) begin
        result_o <= prod_init;
        rd_o     <= rd_i;
        if (set_flags_i) begin
          flag_n_o <= prod_init[N-1];
          flag_z_o <= (prod_init == '0);
        end
      end
    end
  end

  assign busy_o         = (state_q == CALC);
  assign done_o         = (state_q == DONE);
  assign write_enable_o = done_o && (rd_o != REG_PC);
  assign flags_valid_o  = done_o && sf_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: random and directed MUL/MLA against a plain-arithmetic model.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] op_a_i = '0, op_b_i = '0, acc_i = '0;
  logic        accumulate_i = 1'b0, set_flags_i = 1'b0;
  logic [3:0]  rd_i = '0;
  logic        busy_o, done_o, write_enable_o, flag_n_o, flag_z_o, flags_valid_o;
  logic [31:0] result_o;
  logic [3:0]  rd_o;

  mul_unit #(.N(32)) dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .acc_i(acc_i),
    .accumulate_i(accumulate_i), .set_flags_i(set_flags_i), .rd_i(rd_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o),
    .write_enable_o(write_enable_o), .flag_n_o(flag_n_o), .flag_z_o(flag_z_o),
    .flags_valid_o(flags_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        we;
    logic        fv;
    logic        fn;
    logic        fz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic mdl_n = 1'b0, mdl_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Cycles from the accept edge to the edge on which done_o rises.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int hi;
    if (b == 0) return 0;
    hi = 0;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return hi + 1;
`else
    return 32;
`endif
  endfunction

  // Monitor: every done_o cycle must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_ni && done_o) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        timeout("unexpected_done");
      end else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd", {28'd0, rd_o}, {28'd0, e.rd});
        chk("write_enable", {31'd0, write_enable_o}, {31'd0, e.we});
        chk("flags_valid", {31'd0, flags_valid_o}, {31'd0, e.fv});
        chk("flags_nz", {30'd0, flag_n_o, flag_z_o}, {30'd0, e.fn, e.fz});
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic wait_not_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        return;
      end
    end
    timeout("wait_not_busy");
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                       input logic accum, input logic sf, input logic [3:0] rd, output int t0);
    exp_t e;
    bit   ok;
    wait_not_busy(ok);
    t0 = -1;
    if (!ok) return;
    op_a_i = a; op_b_i = b; acc_i = acc;
    accumulate_i = accum; set_flags_i = sf; rd_i = rd;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    e.res = a * b + (accum ? acc : 32'd0);
    if (sf) begin
      mdl_n = e.res[31];
      mdl_z = (e.res == 0);
    end
    e.rd  = rd;
    e.we  = (rd != 4'd15);
    e.fv  = sf;
    e.fn  = mdl_n;
    e.fz  = mdl_z;
    e.lat = exp_lat(b);
    e.t0  = t0;
    sb.push_back(e);
    start_i = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_result"}, result_o, 32'd0);
    chk({tag, "_rd"}, {28'd0, rd_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, write_enable_o}, 32'd0);
    chk({tag, "_flags"}, {29'd0, flag_n_o, flag_z_o, flags_valid_o}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    timeout("drain");
    sb.delete();
  endtask

  initial begin
    int t0, t1, dc;
    logic [31:0] a, b;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Directed: basic MUL, wrap-around MLA, flag cases, PC destination.
    issue(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'd3, t0);
    issue(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 4'd1, t1);
    chk("b2b_gap", t1 - t0, exp_lat(32'd6) + 1);
    issue(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'd2, t0);
    issue(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'd4, t0);
    issue(32'd11, 32'd13, 32'd0, 1'b0, 1'b0, 4'd15, t0);
    issue(32'd3, 32'd0, 32'd9, 1'b1, 1'b0, 4'd5, t0);
    issue(32'h1234_5678, 32'd5, 32'd0, 1'b0, 1'b1, 4'd6, t0);
    drain();

    // start_i pulse while iterating must be dropped.
    issue(32'd100, 32'h8000_0003, 32'd0, 1'b0, 1'b0, 4'd7, t0);
    repeat (5) @(negedge clk);
    chk("busy_during_calc", {31'd0, busy_o}, 32'd1);
    op_a_i = 32'hDEAD_BEEF; op_b_i = 32'd77; rd_i = 4'd9; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts with no completion.
    issue(32'hABCD_0123, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 4'd8, t0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    sb.delete();
    mdl_n = 1'b0;
    mdl_z = 1'b0;
    chk_outputs_zero("midreset");
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", done_cnt, dc);

    // Random operations, multipliers of varied magnitude.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      issue(a, b, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), t0);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
